// File: rtl/muldiv_sequencer_if.sv
// Handshake and datapath-strobe bundle between the MUL/DIV sequencer, the issue
// logic, the divider and the shared-bus datapath.
interface muldiv_sequencer_if;
  logic        start;
  logic [31:0] ir;
  logic        calc_finished;
  logic        PC_out, MAR_rd, IncPC, Read, MDR_rd, MDR_out, IR_rd, Y_rd;
  logic        Zhi_rd, Zlo_rd, Zhi_out, Zlo_out, HI_rd, LO_rd;
  logic [15:0] R_wrt;
  logic [4:0]  op_sel;
  logic        reset_div, busy, done, err;

  modport master (
    input  start, ir, calc_finished,
    output PC_out, MAR_rd, IncPC, Read, MDR_rd, MDR_out, IR_rd, Y_rd,
           Zhi_rd, Zlo_rd, Zhi_out, Zlo_out, HI_rd, LO_rd,
           R_wrt, op_sel, reset_div, busy, done, err
  );

  modport slave (
    output start, ir, calc_finished,
    input  PC_out, MAR_rd, IncPC, Read, MDR_rd, MDR_out, IR_rd, Y_rd,
           Zhi_rd, Zlo_rd, Zhi_out, Zlo_out, HI_rd, LO_rd,
           R_wrt, op_sel, reset_div, busy, done, err
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Moore sequencer for fetch + MUL/DIV execution on the shared-bus datapath.
// Optional DWAIT abort on divider timeout: define DIV_TIMEOUT_EN.
module muldiv_sequencer #(
  parameter int         DIV_TIMEOUT = 40,
  parameter logic [4:0] OP_MUL      = 5'b01110,
  parameter logic [4:0] OP_DIV      = 5'b01111
) (
  input  logic               clk,
  input  logic               clr,
  muldiv_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_DWAIT, S_ZL, S_T5, S_T6, S_DONE, S_ERR
  } state_t;

  typedef struct packed {
    logic        pc_out, mar_rd, inc_pc, read, mdr_rd, mdr_out, ir_rd, y_rd;
    logic        zhi_rd, zlo_rd, zhi_out, zlo_out, hi_rd, lo_rd;
    logic [15:0] r_wrt;
    logic [4:0]  op_sel;
    logic        reset_div, busy, done, err;
  } outs_t;

  state_t     state;
  outs_t      o;
  logic [4:0] opc_q;
  logic [3:0] rb_q;

  // Outputs are registered, so each transition loads the decode of the state
  // being entered; rsel is Ra (straight from ir) for T3 and latched Rb after.
  function automatic outs_t decode(state_t s, logic [4:0] opc, logic [3:0] rsel);
    outs_t d;
    d           = '0;
    d.reset_div = 1'b1;
    d.busy      = (s != S_IDLE);
    case (s)
      S_T0:    {d.pc_out, d.mar_rd, d.inc_pc} = 3'b111;
      S_T1:    {d.read, d.mdr_rd}             = 2'b11;
      S_T2:    {d.mdr_out, d.ir_rd}           = 2'b11;
      S_T3: begin
        d.r_wrt = 16'd1 << rsel;
        d.y_rd  = 1'b1;
      end
      S_T4, S_DWAIT, S_ZL: begin
        d.r_wrt     = 16'd1 << rsel;
        d.op_sel    = opc;
        d.reset_div = !(s == S_T4 && opc == OP_DIV);
        d.zhi_rd    = (s == S_ZL);
        d.zlo_rd    = (s == S_ZL);
      end
      S_T5:    {d.zlo_out, d.lo_rd} = 2'b11;
      S_T6:    {d.zhi_out, d.hi_rd} = 2'b11;
      S_DONE:  d.done = 1'b1;
      S_ERR:   d.err  = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

`ifdef DIV_TIMEOUT_EN
  logic [5:0] to_cnt;
`else
  localparam int unused_div_timeout = DIV_TIMEOUT;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_IDLE;
      o     <= decode(S_IDLE, 5'd0, 4'd0);
      opc_q <= '0;
      rb_q  <= '0;
`ifdef DIV_TIMEOUT_EN
      to_cnt <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          state <= S_T0;
          o     <= decode(S_T0, opc_q, rb_q);
        end
        S_T0: begin state <= S_T1; o <= decode(S_T1, opc_q, rb_q); end
        S_T1: begin state <= S_T2; o <= decode(S_T2, opc_q, rb_q); end
        S_T2: begin
          state <= S_T3;
          opc_q <= bus.ir[31:27];
          rb_q  <= bus.ir[22:19];
          o     <= decode(S_T3, bus.ir[31:27], bus.ir[26:23]);
        end
        S_T3: if (opc_q == OP_MUL || opc_q == OP_DIV) begin
          state <= S_T4;
          o     <= decode(S_T4, opc_q, rb_q);
        end else begin
          state <= S_ERR;
          o     <= decode(S_ERR, opc_q, rb_q);
        end
        S_T4: if (opc_q == OP_DIV) begin
          state <= S_DWAIT;
          o     <= decode(S_DWAIT, opc_q, rb_q);
`ifdef DIV_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end else begin
          state <= S_ZL;
          o     <= decode(S_ZL, opc_q, rb_q);
        end
        S_DWAIT: if (bus.calc_finished) begin
          state <= S_ZL;
          o     <= decode(S_ZL, opc_q, rb_q);
        end
`ifdef DIV_TIMEOUT_EN
        else begin
          to_cnt <= to_cnt + 6'd1;
          if (to_cnt == 6'(DIV_TIMEOUT - 1)) begin
            state <= S_ERR;
            o     <= decode(S_ERR, opc_q, rb_q);
          end
        end
`endif
        S_ZL:   begin state <= S_T5;   o <= decode(S_T5,   opc_q, rb_q); end
        S_T5:   begin state <= S_T6;   o <= decode(S_T6,   opc_q, rb_q); end
        S_T6:   begin state <= S_DONE; o <= decode(S_DONE, opc_q, rb_q); end
        default: begin state <= S_IDLE; o <= decode(S_IDLE, opc_q, rb_q); end
      endcase
    end
  end

  // Instruction immediate/low bits are not used by this sequencer.
  logic unused_ir;
  assign unused_ir = ^bus.ir[18:0];

  assign bus.PC_out    = o.pc_out;
  assign bus.MAR_rd    = o.mar_rd;
  assign bus.IncPC     = o.inc_pc;
  assign bus.Read      = o.read;
  assign bus.MDR_rd    = o.mdr_rd;
  assign bus.MDR_out   = o.mdr_out;
  assign bus.IR_rd     = o.ir_rd;
  assign bus.Y_rd      = o.y_rd;
  assign bus.Zhi_rd    = o.zhi_rd;
  assign bus.Zlo_rd    = o.zlo_rd;
  assign bus.Zhi_out   = o.zhi_out;
  assign bus.Zlo_out   = o.zlo_out;
  assign bus.HI_rd     = o.hi_rd;
  assign bus.LO_rd     = o.lo_rd;
  assign bus.R_wrt     = o.r_wrt;
  assign bus.op_sel    = o.op_sel;
  assign bus.reset_div = o.reset_div;
  assign bus.busy      = o.busy;
  assign bus.done      = o.done;
  assign bus.err       = o.err;

endmodule
